corecomplex: RTL and testbench

CORECOMPLEX -- requirements
Module: corecomplex

---
 rtl/corecomplex.sv | 247 ++++++++++++++++++++++++
 tb/tb_corecomplex.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corecomplex.sv
// 3x4 grid of tiny accumulator cores with blocking rendezvous links, plus a hex
// to seven-segment decoder. Each core runs a looping program from a shared ROM.

module hex_to_7seg (
    input  logic [3:0] hexval,
    output logic [6:0] ledcode
);
    // Active-low segments, bit0 = a ... bit6 = g
    always_comb begin
        case (hexval)
            4'h0:    ledcode = 7'h40;
            4'h1:    ledcode = 7'h79;
            4'h2:    ledcode = 7'h24;
            4'h3:    ledcode = 7'h30;
            4'h4:    ledcode = 7'h19;
            4'h5:    ledcode = 7'h12;
            4'h6:    ledcode = 7'h02;
            4'h7:    ledcode = 7'h78;
            4'h8:    ledcode = 7'h00;
            4'h9:    ledcode = 7'h10;
            4'hA:    ledcode = 7'h08;
            4'hB:    ledcode = 7'h03;
            4'hC:    ledcode = 7'h46;
            4'hD:    ledcode = 7'h21;
            4'hE:    ledcode = 7'h06;
            default: ledcode = 7'h0E;
        endcase
    end
endmodule

module corecomplex #(
    parameter int NCORES = 12,
    parameter int MAXLEN = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         pLength [0:NCORES-1],
    input  logic [15:0]        prog    [0:NCORES*MAXLEN-1],
    output logic signed [10:0] acc     [0:NCORES-1]
);
    localparam logic [2:0] R_ACC   = 3'd0;
    localparam logic [2:0] R_LEFT  = 3'd2;
    localparam logic [2:0] R_RIGHT = 3'd3;
    localparam logic [2:0] R_UP    = 3'd4;
    localparam logic [2:0] R_DOWN  = 3'd5;

    function automatic logic is_port(input logic [2:0] r);
        return (r >= R_LEFT) && (r <= R_DOWN);
    endfunction

    function automatic logic signed [10:0] sat(input logic signed [12:0] v);
        if (v > 13'sd999)
            return 11'sd999;
        else if (v < -13'sd999)
            return -11'sd999;
        else
            return v[10:0];
    endfunction

    // Link requests are derived from registered state only, so every core sees
    // the same picture of its neighbours regardless of evaluation order.
    logic               wr_en  [0:NCORES-1];
    logic [2:0]         wr_dir [0:NCORES-1];
    logic signed [10:0] wr_val [0:NCORES-1];
    logic               rd_en  [0:NCORES-1];
    logic [2:0]         rd_dir [0:NCORES-1];

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        localparam int  COL   = i % 4;
        localparam int  ROW   = i / 4;
        localparam bit  HAS_L = COL > 0;
        localparam bit  HAS_R = (COL < 3) && (i + 1 < NCORES);
        localparam bit  HAS_U = ROW > 0;
        localparam bit  HAS_D = i + 4 < NCORES;
        localparam int  N_L   = HAS_L ? i - 1 : i;
        localparam int  N_R   = HAS_R ? i + 1 : i;
        localparam int  N_U   = HAS_U ? i - 4 : i;
        localparam int  N_D   = HAS_D ? i + 4 : i;

        logic signed [10:0] acc_q, bak_q, hold_q;
        logic [3:0]         pc_q;
        logic               hold_v_q;

        logic [15:0]        ins;
        logic [3:0]         plen;
        logic               active;
        logic [1:0]         cls;
        logic [2:0]         sub, src, dst;
        logic [3:0]         tgt;
        logic               src_p, dst_p, sub_p, is_mov, reads_src;

        assign plen   = pLength[i];
        assign active = plen != 4'd0;

        always_comb begin
            ins = '0;
            for (int k = 0; k < MAXLEN; k++)
                if (pc_q == 4'(k)) ins = prog[i*MAXLEN + k];
        end

        assign cls       = ins[15:14];
        assign sub       = ins[13:11];
        assign src       = ins[5:3];
        assign dst       = ins[2:0];
        assign tgt       = ins[3:0];
        assign src_p     = is_port(src);
        assign dst_p     = is_port(dst);
        assign sub_p     = is_port(sub);
        assign is_mov    = (cls == 2'b00) && (sub == 3'd6);
        assign reads_src = (cls == 2'b00) && ((sub == 3'd4) || (sub == 3'd5) || (sub == 3'd7));

        logic signed [12:0] acc13, imm13, srcv13, off13, jro_sum;
        logic signed [10:0] srcv, rd_val;
        logic               rd_ok, wr_ok, src_ready, taken;
        logic [4:0]         pc_inc;
        logic [3:0]         pc_adv, jro_pc, tgt_pc;

        assign acc13 = {{2{acc_q[10]}}, acc_q};
        assign imm13 = {{2{ins[10]}}, ins[10:0]};

        // A port-to-port MOV reads while its hold is empty, then writes it out.
        assign rd_en[i]  = active && src_p && (reads_src || (is_mov && !(dst_p && hold_v_q)));
        assign rd_dir[i] = src;
        assign wr_en[i]  = active && ((is_mov && dst_p && (!src_p || hold_v_q)) ||
                                      ((cls == 2'b11) && sub_p));
        assign wr_dir[i] = (cls == 2'b11) ? sub : dst;
        assign wr_val[i] = (cls == 2'b11) ? sat(imm13) :
                           src_p          ? hold_q     :
                           (src == R_ACC) ? acc_q      : '0;

        always_comb begin
            rd_ok  = 1'b0;
            rd_val = '0;
            wr_ok  = 1'b0;
            case (src)
                R_LEFT:  if (HAS_L) begin rd_ok = wr_en[N_L] && (wr_dir[N_L] == R_RIGHT); rd_val = wr_val[N_L]; end
                R_RIGHT: if (HAS_R) begin rd_ok = wr_en[N_R] && (wr_dir[N_R] == R_LEFT);  rd_val = wr_val[N_R]; end
                R_UP:    if (HAS_U) begin rd_ok = wr_en[N_U] && (wr_dir[N_U] == R_DOWN);  rd_val = wr_val[N_U]; end
                R_DOWN:  if (HAS_D) begin rd_ok = wr_en[N_D] && (wr_dir[N_D] == R_UP);    rd_val = wr_val[N_D]; end
                default: ;
            endcase
            rd_ok = rd_ok && rd_en[i];
            case (wr_dir[i])
                R_LEFT:  if (HAS_L) wr_ok = rd_en[N_L] && (rd_dir[N_L] == R_RIGHT);
                R_RIGHT: if (HAS_R) wr_ok = rd_en[N_R] && (rd_dir[N_R] == R_LEFT);
                R_UP:    if (HAS_U) wr_ok = rd_en[N_U] && (rd_dir[N_U] == R_DOWN);
                R_DOWN:  if (HAS_D) wr_ok = rd_en[N_D] && (rd_dir[N_D] == R_UP);
                default: ;
            endcase
            wr_ok = wr_ok && wr_en[i];
        end

        assign srcv      = src_p ? rd_val : ((src == R_ACC) ? acc_q : '0);
        assign srcv13    = {{2{srcv[10]}}, srcv};
        assign src_ready = !src_p || rd_ok;

        assign pc_inc  = {1'b0, pc_q} + 5'd1;
        assign pc_adv  = (pc_inc >= {1'b0, plen}) ? 4'd0 : pc_inc[3:0];
        assign tgt_pc  = (tgt >= plen) ? 4'd0 : tgt;
        assign off13   = (cls == 2'b10) ? imm13 : srcv13;
        assign jro_sum = $signed({9'b0, pc_q}) + off13;

        always_comb begin
            if (jro_sum < 13'sd0)
                jro_pc = 4'd0;
            else if (jro_sum >= $signed({9'b0, plen}))
                jro_pc = plen - 4'd1;
            else
                jro_pc = jro_sum[3:0];
        end

        always_comb begin
            case (sub)
                3'd0:    taken = 1'b1;
                3'd1:    taken = acc_q == 11'sd0;
                3'd2:    taken = acc_q != 11'sd0;
                3'd3:    taken = acc_q > 11'sd0;
                3'd4:    taken = acc_q < 11'sd0;
                default: taken = 1'b0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                acc_q    <= '0;
                bak_q    <= '0;
                hold_q   <= '0;
                hold_v_q <= 1'b0;
                pc_q     <= '0;
            end else if (active) begin
                case (cls)
                    2'b00: begin
                        case (sub)
                            3'd0: pc_q <= pc_adv;
                            3'd1: begin acc_q <= bak_q; bak_q <= acc_q; pc_q <= pc_adv; end
                            3'd2: begin bak_q <= acc_q; pc_q <= pc_adv; end
                            3'd3: begin acc_q <= sat(-acc13); pc_q <= pc_adv; end
                            3'd4: if (src_ready) begin acc_q <= sat(acc13 + srcv13); pc_q <= pc_adv; end
                            3'd5: if (src_ready) begin acc_q <= sat(acc13 - srcv13); pc_q <= pc_adv; end
                            3'd6: begin
                                if (src_p && dst_p) begin
                                    if (!hold_v_q) begin
                                        if (rd_ok) begin
                                            hold_q   <= rd_val;
                                            hold_v_q <= 1'b1;
                                        end
                                    end else if (wr_ok) begin
                                        hold_v_q <= 1'b0;
                                        pc_q     <= pc_adv;
                                    end
                                end else if (dst_p) begin
                                    if (wr_ok) pc_q <= pc_adv;
                                end else if (src_ready) begin
                                    if (dst == R_ACC) acc_q <= srcv;
                                    pc_q <= pc_adv;
                                end
                            end
                            default: if (src_ready) pc_q <= jro_pc;
                        endcase
                    end
                    2'b01: begin
                        acc_q <= ins[13] ? sat(acc13 - imm13) : sat(acc13 + imm13);
                        pc_q  <= pc_adv;
                    end
                    2'b10: begin
                        if (sub <= 3'd4)
                            pc_q <= taken ? tgt_pc : pc_adv;
                        else if (sub == 3'd5)
                            pc_q <= jro_pc;
                        else
                            pc_q <= pc_adv;
                    end
                    default: begin
                        if (sub_p) begin
                            if (wr_ok) pc_q <= pc_adv;
                        end else begin
                            if (sub == R_ACC) acc_q <= sat(imm13);
                            pc_q <= pc_adv;
                        end
                    end
                endcase
            end
        end

        assign acc[i] = acc_q;
    end
endmodule

// File: tb/tb_corecomplex.sv
// Self-checking bench for corecomplex: directed scenarios plus random programs
// compared cycle by cycle against a behavioural grid model.

module tb_corecomplex;
    localparam int NC = 12;
    localparam int ML = 15;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [3:0]         plen_s [0:NC-1];
    logic [15:0]        prog_s [0:NC*ML-1];
    logic signed [10:0] acc_o  [0:NC-1];
    logic [3:0]         hexval;
    logic [6:0]         ledcode;

    int checks = 0;
    int errors = 0;

    int m_acc [NC], m_bak [NC], m_pc [NC], m_hold [NC];
    bit m_hv [NC];

    corecomplex #(.NCORES(NC), .MAXLEN(ML)) dut (
        .clk(clk), .rst(rst), .pLength(plen_s), .prog(prog_s), .acc(acc_o)
    );

    hex_to_7seg u_hex (.hexval(hexval), .ledcode(ledcode));

    always #5 clk = ~clk;

    // ---------------- instruction encoders ----------------
    function automatic logic [15:0] e_op(input logic [2:0] sub, input logic [2:0] s, input logic [2:0] d);
        return {2'b00, sub, 5'b0, s, d};
    endfunction
    function automatic logic [15:0] e_addi(input int v, input bit neg);
        logic [10:0] im = 11'(v);
        return {2'b01, neg, 2'b00, im};
    endfunction
    function automatic logic [15:0] e_movi(input logic [2:0] d, input int v);
        logic [10:0] im = 11'(v);
        return {2'b11, d, im};
    endfunction
    function automatic logic [15:0] e_jmp(input logic [2:0] sub, input logic [3:0] t);
        return {2'b10, sub, 7'b0, t};
    endfunction

    // ---------------- behavioural model ----------------
    function automatic int sat(input int v);
        return (v > 999) ? 999 : (v < -999) ? -999 : v;
    endfunction
    function automatic bit is_port(input int r);
        return r >= 2 && r <= 5;
    endfunction
    function automatic int nb(input int c, input int d);
        int row = c / 4, col = c % 4;
        case (d)
            2: return (col > 0) ? c - 1 : -1;
            3: return (col < 3 && c + 1 < NC) ? c + 1 : -1;
            4: return (row > 0) ? c - 4 : -1;
            5: return (c + 4 < NC) ? c + 4 : -1;
            default: return -1;
        endcase
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NC; c++) begin
            m_acc[c] = 0; m_bak[c] = 0; m_pc[c] = 0; m_hold[c] = 0; m_hv[c] = 0;
        end
    endtask

    task automatic m_step();
        int wd [NC], wv [NC], rd [NC], gv [NC];
        bit got [NC], sent [NC];
        for (int c = 0; c < NC; c++) begin
            logic [15:0] w;
            int cls, sub, s, d, imm;
            wd[c] = -1; rd[c] = -1; wv[c] = 0;
            if (plen_s[c] == 0) continue;
            w = prog_s[c*ML + m_pc[c]];
            cls = int'(w[15:14]); sub = int'(w[13:11]); s = int'(w[5:3]); d = int'(w[2:0]);
            imm = int'($signed(w[10:0]));
            if (cls == 0 && (sub == 4 || sub == 5 || sub == 7) && is_port(s)) rd[c] = s;
            if (cls == 0 && sub == 6) begin
                if (is_port(s) && is_port(d)) begin
                    if (m_hv[c]) begin wd[c] = d; wv[c] = m_hold[c]; end
                    else rd[c] = s;
                end else if (is_port(s)) rd[c] = s;
                else if (is_port(d)) begin wd[c] = d; wv[c] = (s == 0) ? m_acc[c] : 0; end
            end
            if (cls == 3 && is_port(sub)) begin wd[c] = sub; wv[c] = sat(imm); end
        end
        for (int c = 0; c < NC; c++) begin
            int n;
            got[c] = 0; sent[c] = 0; gv[c] = 0;
            if (rd[c] >= 0) begin
                n = nb(c, rd[c]);
                if (n >= 0 && wd[n] == (rd[c] ^ 1)) begin got[c] = 1; gv[c] = wv[n]; end
            end
            if (wd[c] >= 0) begin
                n = nb(c, wd[c]);
                if (n >= 0 && rd[n] == (wd[c] ^ 1)) sent[c] = 1;
            end
        end
        for (int c = 0; c < NC; c++) begin
            logic [15:0] w;
            int cls, sub, s, d, imm, pl, nxt, sv, t;
            bit ready, tk;
            pl = int'(plen_s[c]);
            if (pl == 0) continue;
            w = prog_s[c*ML + m_pc[c]];
            cls = int'(w[15:14]); sub = int'(w[13:11]); s = int'(w[5:3]); d = int'(w[2:0]);
            imm = int'($signed(w[10:0]));
            nxt = (m_pc[c] + 1 >= pl) ? 0 : m_pc[c] + 1;
            ready = !is_port(s) || got[c];
            sv = is_port(s) ? gv[c] : (s == 0 ? m_acc[c] : 0);
            if (cls == 0) begin
                case (sub)
                    0: m_pc[c] = nxt;
                    1: begin t = m_acc[c]; m_acc[c] = m_bak[c]; m_bak[c] = t; m_pc[c] = nxt; end
                    2: begin m_bak[c] = m_acc[c]; m_pc[c] = nxt; end
                    3: begin m_acc[c] = sat(-m_acc[c]); m_pc[c] = nxt; end
                    4: if (ready) begin m_acc[c] = sat(m_acc[c] + sv); m_pc[c] = nxt; end
                    5: if (ready) begin m_acc[c] = sat(m_acc[c] - sv); m_pc[c] = nxt; end
                    6: begin
                        if (is_port(s) && is_port(d)) begin
                            if (!m_hv[c]) begin
                                if (got[c]) begin m_hold[c] = gv[c]; m_hv[c] = 1; end
                            end else if (sent[c]) begin m_hv[c] = 0; m_pc[c] = nxt; end
                        end else if (is_port(d)) begin
                            if (sent[c]) m_pc[c] = nxt;
                        end else if (ready) begin
                            if (d == 0) m_acc[c] = sv;
                            m_pc[c] = nxt;
                        end
                    end
                    default: if (ready) begin
                        t = m_pc[c] + sv;
                        m_pc[c] = (t < 0) ? 0 : (t > pl - 1) ? pl - 1 : t;
                    end
                endcase
            end else if (cls == 1) begin
                m_acc[c] = sat(w[13] ? m_acc[c] - imm : m_acc[c] + imm);
                m_pc[c] = nxt;
            end else if (cls == 2) begin
                if (sub <= 4) begin
                    tk = (sub == 0) || (sub == 1 && m_acc[c] == 0) || (sub == 2 && m_acc[c] != 0) ||
                         (sub == 3 && m_acc[c] > 0) || (sub == 4 && m_acc[c] < 0);
                    t = int'(w[3:0]);
                    m_pc[c] = tk ? ((t >= pl) ? 0 : t) : nxt;
                end else if (sub == 5) begin
                    t = m_pc[c] + imm;
                    m_pc[c] = (t < 0) ? 0 : (t > pl - 1) ? pl - 1 : t;
                end else m_pc[c] = nxt;
            end else begin
                if (is_port(sub)) begin
                    if (sent[c]) m_pc[c] = nxt;
                end else begin
                    if (sub == 0) m_acc[c] = sat(imm);
                    m_pc[c] = nxt;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        if (!rst) m_reset(); else m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int c = 0; c < NC; c++) plen_s[c] = 4'd0;
        for (int k = 0; k < NC*ML; k++) prog_s[k] = 16'h0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_prog();
        for (int k = 0; k < NC*ML; k++) prog_s[k] = 16'($urandom);
        for (int c = 0; c < NC; c++) plen_s[c] = 4'($urandom_range(0, 15));
        rst = 1'b0;
        tick();
        tick();
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (acc_o[c] !== 11'sd0) begin
                errors++;
                $display("FAIL reset_acc core %0d got %0d want 0", c, acc_o[c]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_addi_sat();
        clear_prog();
        prog_s[0] = e_addi(1, 1'b0);
        plen_s[0] = 4'd1;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (acc_o[0] !== 11'(k)) begin
                errors++;
                $display("FAIL addi_count cycle %0d got %0d want %0d", k, acc_o[0], k);
            end
        end
        for (int k = 0; k < 1000; k++) tick();
        checks++;
        if (acc_o[0] !== 11'sd999) begin
            errors++;
            $display("FAIL addi_saturate got %0d want 999", acc_o[0]);
        end
    endtask

    task automatic test_rendezvous();
        clear_prog();
        prog_s[0]  = e_movi(3'd3, 5);
        prog_s[ML] = e_op(3'd4, 3'd2, 3'd0);
        plen_s[0] = 4'd1;
        plen_s[1] = 4'd1;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (acc_o[1] !== 11'(5*k) || acc_o[0] !== 11'sd0) begin
                errors++;
                $display("FAIL rendezvous cycle %0d got acc1=%0d acc0=%0d want acc1=%0d acc0=0",
                         k, acc_o[1], acc_o[0], 5*k);
            end
        end
    endtask

    task automatic test_unmatched_stall();
        clear_prog();
        prog_s[ML] = e_op(3'd4, 3'd2, 3'd0);
        plen_s[1] = 4'd1;
        prog_s[3*ML] = e_op(3'd4, 3'd3, 3'd0);
        plen_s[3] = 4'd1;
        do_reset();
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (acc_o[1] !== 11'sd0 || acc_o[3] !== 11'sd0) begin
            errors++;
            $display("FAIL stall_forever got acc1=%0d acc3=%0d want 0 0", acc_o[1], acc_o[3]);
        end
    endtask

    task automatic test_jlz_loop();
        clear_prog();
        prog_s[0] = e_movi(3'd0, -3);
        prog_s[1] = e_jmp(3'd4, 4'd0);
        prog_s[2] = e_addi(7, 1'b0);
        plen_s[0] = 4'd3;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (acc_o[0] !== -11'sd3) begin
                errors++;
                $display("FAIL jlz_loop cycle %0d got %0d want -3", k, acc_o[0]);
            end
        end
    endtask

    task automatic test_subi_neg();
        int want [4] = '{-999, -999, 999, 999};
        clear_prog();
        prog_s[0] = e_addi(999, 1'b1);
        prog_s[1] = e_addi(999, 1'b1);
        prog_s[2] = e_op(3'd3, 3'd0, 3'd0);
        prog_s[3] = e_jmp(3'd0, 4'd3);
        plen_s[0] = 4'd4;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (acc_o[0] !== 11'(want[k])) begin
                errors++;
                $display("FAIL subi_neg step %0d got %0d want %0d", k, acc_o[0], want[k]);
            end
        end
    endtask

    task automatic test_mov_two_phase();
        int want [6] = '{0, 7, 7, 9, 9, 7};
        clear_prog();
        prog_s[0] = e_movi(3'd3, 7);
        prog_s[1] = e_movi(3'd3, 9);
        plen_s[0] = 4'd2;
        prog_s[ML]   = e_op(3'd6, 3'd2, 3'd3);
        plen_s[1] = 4'd1;
        prog_s[2*ML] = e_op(3'd6, 3'd2, 3'd0);
        plen_s[2] = 4'd1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (acc_o[2] !== 11'(want[k])) begin
                errors++;
                $display("FAIL mov_two_phase cycle %0d got %0d want %0d", k + 1, acc_o[2], want[k]);
            end
        end
    endtask

    task automatic test_reset_midstall();
        clear_prog();
        prog_s[ML]   = e_op(3'd4, 3'd2, 3'd0);
        plen_s[1] = 4'd1;
        prog_s[2*ML] = e_addi(1, 1'b0);
        plen_s[2] = 4'd1;
        do_reset();
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if (acc_o[2] !== 11'sd6 || acc_o[1] !== 11'sd0) begin
            errors++;
            $display("FAIL pre_reset got acc2=%0d acc1=%0d want 6 0", acc_o[2], acc_o[1]);
        end
        rst = 1'b0;
        tick();
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (acc_o[c] !== 11'sd0) begin
                errors++;
                $display("FAIL midstall_reset core %0d got %0d want 0", c, acc_o[c]);
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if (acc_o[2] !== 11'sd1) begin
            errors++;
            $display("FAIL first_after_reset got %0d want 1", acc_o[2]);
        end
    endtask

    task automatic test_hex();
        logic [6:0] seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int h = 0; h < 16; h++) begin
            hexval = 4'(h);
            #1;
            checks++;
            if (ledcode !== seg_tab[h]) begin
                errors++;
                $display("FAIL hex_seg digit %0d got %02h want %02h", h, ledcode, seg_tab[h]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            clear_prog();
            for (int c = 0; c < NC; c++) begin
                plen_s[c] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                for (int k = 0; k < ML; k++) begin
                    case ($urandom_range(0, 3))
                        0: prog_s[c*ML+k] = e_op(3'd6, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)));
                        1: prog_s[c*ML+k] = e_movi(3'($urandom_range(2, 5)), $urandom_range(0, 600) - 300);
                        2: prog_s[c*ML+k] = e_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                        default: prog_s[c*ML+k] = 16'($urandom);
                    endcase
                end
            end
            do_reset();
            for (int k = 0; k < 40; k++) begin
                rst = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
                tick();
                for (int c = 0; c < NC; c++) begin
                    logic signed [10:0] e = 11'(m_acc[c]);
                    checks++;
                    if (acc_o[c] !== e) begin
                        errors++;
                        $display("FAIL random_acc round %0d cycle %0d core %0d got %0d want %0d",
                                 r, k, c, acc_o[c], e);
                    end
                end
            end
            rst = 1'b1;
        end
    endtask

    initial begin
        hexval = 4'd0;
        clear_prog();
        m_reset();
        test_reset();
        test_addi_sat();
        test_rendezvous();
        test_unmatched_stall();
        test_jlz_loop();
        test_subi_neg();
        test_mov_two_phase();
        test_reset_midstall();
        test_hex();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
